// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file command sequencer:
// opcode and FSM state encodings plus default widths.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational arithmetic for the sequencer: ADD carry-out, SUB borrow,
// pass-through of operand a for LOAD and READ.
module seq_alu
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        wide = {1'b0, a};
        unique case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};  // top bit set exactly when a < b
            default: wide = {1'b0, a};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer driving an external register file through
// IDLE -> (RD) -> (WR) -> DONE, with a one-cycle completion pulse.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_read_register_1,
    output logic [ADDR_W-1:0] rf_read_register_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    output logic [ADDR_W-1:0] rf_write_register,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry
);

    state_e            state, state_next;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic              carry_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (rf_read_data_1),
        .b      (rf_read_data_2),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (cmd_valid) state_next = (op_e'(cmd_op) == OP_LOAD) ? S_WR : S_RD;
            S_RD:   state_next = (op_q == OP_READ) ? S_DONE : S_WR;
            S_WR:   state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
        endcase
    end

    assign cmd_ready    = (state == S_IDLE);
    assign rf_reg_write = (state == S_WR);
    assign rsp_valid    = (state == S_DONE);

    // Selects and write data only change on the edge entering RD or WR, so they hold elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q               <= OP_LOAD;
            rd_q               <= '0;
            carry_q            <= 1'b0;
            rf_read_register_1 <= '0;
            rf_read_register_2 <= '0;
            rf_write_register  <= '0;
            rf_write_data      <= '0;
            rsp_data           <= '0;
            rsp_carry          <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        rd_q    <= cmd_rd;
                        carry_q <= 1'b0;
                        if (op_e'(cmd_op) == OP_LOAD) begin
                            rf_write_register <= cmd_rd;
                            rf_write_data     <= cmd_imm;
                        end else begin
                            rf_read_register_1 <= cmd_rs1;
                            rf_read_register_2 <= cmd_rs2;
                        end
                    end
                end
                S_RD: begin
                    if (op_q == OP_READ) begin
                        rsp_data  <= alu_result;
                        rsp_carry <= 1'b0;
                    end else begin
                        rf_write_register <= rd_q;
                        rf_write_data     <= alu_result;
                        carry_q           <= alu_carry;
                    end
                end
                S_WR: begin
                    rsp_data  <= rf_write_data;
                    rsp_carry <= carry_q;
                end
                S_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: regfile_sequencer paired with a 4x32 register file model.
module tb_regfile_sequencer;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic [1:0]  rf_read_register_1, rf_read_register_2, rf_write_register;
    logic [31:0] rf_read_data_1, rf_read_data_2, rf_write_data;
    logic        rf_reg_write;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_carry;

    logic [31:0] regs [4];
    int vectors     = 0;
    int miscompares = 0;

    regfile_sequencer #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_rd             (cmd_rd),
        .cmd_rs1            (cmd_rs1),
        .cmd_rs2            (cmd_rs2),
        .cmd_imm            (cmd_imm),
        .rf_read_register_1 (rf_read_register_1),
        .rf_read_register_2 (rf_read_register_2),
        .rf_read_data_1     (rf_read_data_1),
        .rf_read_data_2     (rf_read_data_2),
        .rf_write_register  (rf_write_register),
        .rf_write_data      (rf_write_data),
        .rf_reg_write       (rf_reg_write),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_carry          (rsp_carry)
    );

    always #5 clk = ~clk;

    assign rf_read_data_1 = regs[rf_read_register_1];
    assign rf_read_data_2 = regs[rf_read_register_2];
    always @(posedge clk) if (rf_reg_write) regs[rf_write_register] <= rf_write_data;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one command; latency counts samples from the accept edge to rsp_valid.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [31:0] imm, input bit hold,
                           output int lat, output int nwr, output logic [1:0] wsel,
                           output bit ready_ok);
        int guard = 0;
        while (!cmd_ready && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        ready_ok  = cmd_ready;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        lat = 0; nwr = 0; wsel = 2'b00;
        do begin
            @(posedge clk); #1; lat++;
            if (!hold) cmd_valid = 1'b0;
            cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_imm = ~imm;
            if (rf_reg_write) begin nwr++; wsel = rf_write_register; end
            if (cmd_ready) ready_ok = 1'b0;
        end while (!rsp_valid && lat < 10);
    endtask

    task automatic exec(input string name, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [31:0] imm,
                        input bit hold, input int exp_lat, input bit exp_wr,
                        input logic [31:0] exp_data, input logic exp_carry);
        int lat, nwr;
        logic [1:0] wsel;
        bit ready_ok;
        run_cmd(op, rd, rs1, rs2, imm, hold, lat, nwr, wsel, ready_ok);
        check({name, " latency"}, lat, exp_lat);
        check({name, " write pulses"}, nwr, exp_wr ? 1 : 0);
        check({name, " write select"}, wsel, exp_wr ? rd : 2'b00);
        check({name, " ready handshake"}, ready_ok, 1);
        check({name, " rsp_data"}, rsp_data, exp_data);
        check({name, " rsp_carry"}, rsp_carry, exp_carry);
        if (exp_wr) check({name, " regfile"}, regs[rd], exp_data);
    endtask

    initial begin
        int bad_wr, bad_rsp;
        reset = 1'b0; cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_rd = 2'b00; cmd_rs1 = 2'b00; cmd_rs2 = 2'b00; cmd_imm = '0;
        #12;
        check("reset rf_reg_write", rf_reg_write, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_carry", rsp_carry, 0);
        check("reset selects", {rf_read_register_1, rf_read_register_2, rf_write_register}, 0);
        check("reset write data", rf_write_data, 0);
        #5 reset = 1'b1;
        #1 check("ready after reset", cmd_ready, 1);

        exec("load r1", 2'b00, 2'd1, 2'd0, 2'd0, 32'hFFF7AAAA, 0, 2, 1, 32'hFFF7AAAA, 0);

        exec("load r1 max", 2'b00, 2'd1, 2'd0, 2'd0, 32'hFFFFFFFF, 0, 2, 1, 32'hFFFFFFFF, 0);
        exec("load r2", 2'b00, 2'd2, 2'd0, 2'd0, 32'h00000002, 0, 2, 1, 32'h00000002, 0);
        exec("add carry", 2'b01, 2'd3, 2'd1, 2'd2, 32'h0, 0, 3, 1, 32'h00000001, 1);

        exec("load r0", 2'b00, 2'd0, 2'd0, 2'd0, 32'h00000005, 0, 2, 1, 32'h00000005, 0);
        exec("load r2 seven", 2'b00, 2'd2, 2'd0, 2'd0, 32'h00000007, 0, 2, 1, 32'h00000007, 0);
        exec("sub borrow", 2'b10, 2'd0, 2'd0, 2'd2, 32'h0, 0, 3, 1, 32'hFFFFFFFE, 1);
        exec("add no carry", 2'b01, 2'd2, 2'd2, 2'd2, 32'h0, 0, 3, 1, 32'h0000000E, 0);
        exec("sub no borrow", 2'b10, 2'd1, 2'd2, 2'd3, 32'h0, 0, 3, 1, 32'h0000000D, 0);

        exec("load r3", 2'b00, 2'd3, 2'd0, 2'd0, 32'h1234AAAA, 0, 2, 1, 32'h1234AAAA, 0);
        exec("read r3", 2'b11, 2'd0, 2'd3, 2'd1, 32'h0, 0, 2, 0, 32'h1234AAAA, 0);
        @(posedge clk); #1;
        check("rsp hold valid", rsp_valid, 0);
        check("rsp hold data", rsp_data, 32'h1234AAAA);

        exec("b2b load r0", 2'b00, 2'd0, 2'd0, 2'd0, 32'h11111111, 1, 2, 1, 32'h11111111, 0);
        exec("b2b load r1", 2'b00, 2'd1, 2'd0, 2'd0, 32'h22222222, 1, 2, 1, 32'h22222222, 0);
        exec("b2b add r2", 2'b01, 2'd2, 2'd0, 2'd1, 32'h0, 1, 3, 1, 32'h33333333, 0);
        cmd_valid = 1'b0;
        check("b2b r3 untouched", regs[3], 32'h1234AAAA);

        // Abort an ADD during its RD cycle.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort in RD", {rf_reg_write, rsp_valid, cmd_ready}, 3'b000);
        reset = 1'b0;
        #1;
        check("abort rf_reg_write", rf_reg_write, 0);
        check("abort rsp_valid", rsp_valid, 0);
        check("abort rsp outputs", {rsp_carry, rsp_data}, 0);
        check("abort selects", {rf_read_register_1, rf_read_register_2, rf_write_register}, 0);
        check("abort write data", rf_write_data, 0);
        bad_wr = 0; bad_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) reset = 1'b1;
            if (rf_reg_write) bad_wr++;
            if (rsp_valid) bad_rsp++;
        end
        check("abort no write", bad_wr, 0);
        check("abort no response", bad_rsp, 0);
        check("abort r3 kept", regs[3], 32'h1234AAAA);
        exec("load after abort", 2'b00, 2'd3, 2'd0, 2'd0, 32'hCAFEF00D, 0, 2, 1, 32'hCAFEF00D, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 32, register data width.
- ADDR_W, 2, register index width (4 registers).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 READ.
- cmd_rd  input  ADDR_W  destination register.
- cmd_rs1  input  ADDR_W  source register 1.
- cmd_rs2  input  ADDR_W  source register 2.
- cmd_imm  input  DATA_W  immediate value for LOAD.
- rf_read_register_1  output  ADDR_W  register-file read port 1 select.
- rf_read_register_2  output  ADDR_W  register-file read port 2 select.
- rf_read_data_1  input  DATA_W  register-file read port 1 data (combinational).
- rf_read_data_2  input  DATA_W  register-file read port 2 data (combinational).
- rf_write_register  output  ADDR_W  register-file write select.
- rf_write_data  output  DATA_W  register-file write data.
- rf_reg_write  output  1  register-file write enable.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_data  output  DATA_W  result (written value, or rs1 value for READ).
- rsp_carry  output  1  ADD carry-out / SUB borrow; 0 for LOAD and READ.

Function
REQ-003 The FSM SHALL have four states, IDLE, RD, WR and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-004 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; op, rd, rs1, rs2 and imm SHALL be latched at that edge and ignored afterwards.
REQ-005 Transitions SHALL be:
- IDLE->WR for LOAD; IDLE->RD for ADD, SUB and READ.
- RD->WR for ADD and SUB; RD->DONE for READ.
- WR->DONE.
- DONE->IDLE unconditionally.
REQ-006 In RD, rf_read_register_1 and rf_read_register_2 SHALL hold the latched rs1 and rs2, and read data SHALL be captured at the edge that leaves RD.
REQ-007 In WR, rf_reg_write SHALL be 1 for exactly that one cycle, with rf_write_register and rf_write_data stable for the whole cycle; rf_reg_write SHALL be 0 in every other state.
REQ-008 LOAD SHALL write imm. ADD SHALL write (rs1+rs2) mod 2^DATA_W, with carry = bit DATA_W of the sum. SUB SHALL write (rs1-rs2) mod 2^DATA_W, with carry = 1 when rs1<rs2 unsigned.
REQ-009 rsp_valid SHALL be 1 only in DONE; rsp_data and rsp_carry SHALL be valid when rsp_valid=1 and hold their values until the next DONE.
REQ-010 Latency from the accept edge to rsp_valid high SHALL be 2 cycles for LOAD, 3 for ADD and SUB, and 2 for READ; back-to-back commands SHALL be accepted no sooner than the cycle after DONE.
REQ-011 rd equal to rs1 or rs2 SHALL be legal; the sources SHALL be the values read in RD.
REQ-012 Outside RD, the read selects SHALL hold their last values; outside WR, the write select and data SHALL hold their last values.

Reset
REQ-013 While reset=0, the block SHALL force: state IDLE; cmd_ready=1 once reset is released; rf_reg_write=0; rsp_valid=0; rsp_carry=0; rsp_data=0; all rf selects=0; rf_write_data=0.
REQ-014 Reset asserted mid-command SHALL abort it immediately: no write is issued after the assertion, and no response pulse follows.

Structure
REQ-015 The opcode encodings, the state encoding and DATA_W/ADDR_W defaults SHALL live in a shared package, regfile_pkg.
REQ-016 Arithmetic SHALL be a sub-module, seq_alu (op, a, b -> result, carry), which is combinational; the FSM and registers SHALL live in regfile_sequencer.

Verification
REQ-017 The bench SHALL pair the DUT with a 4x32 register file model and cover these scenarios:
- LOAD rd=1 imm=FFF7AAAA -> rf_reg_write pulses 1 cycle with select 01; rsp_valid 2 cycles after accept; rsp_data=FFF7AAAA; reg1=FFF7AAAA.
- Regs r1=FFFFFFFF, r2=00000002; ADD rd=3 -> reg3=00000001, rsp_carry=1, latency 3.
- Regs r0=5, r2=7; SUB rd=0 rs1=0 rs2=2 -> reg0=FFFFFFFE, rsp_carry=1; covers rd==rs1.
- READ rs1=3 after load of 1234AAAA -> rsp_data=1234AAAA; rf_reg_write never asserted; latency 2.
- cmd_valid held high for three commands -> cmd_ready low from accept through DONE; each accepted exactly once, in order.
- Reset dropped during the RD cycle of an ADD -> no rf_reg_write, no rsp_valid; all outputs at reset values; next LOAD completes normally.
